sevenseg_mux_driver: RTL
========================

// Module: sevenseg_mux_driver
// PURPOSE
//  Time-multiplexed N-digit 7-segment display driver for hex digits 0-F.
//  - Double-buffered digit storage; swaps only at frame boundaries, so no tearing.
//  - Refresh prescaler with an anti-ghosting dead cycle between digits.
//  - Selectable common-cathode / common-anode output polarity.
//  - Sits between register/status logic and the board display pins.
// PARAMETERS
//  NUM_DIGITS    4     digits driven, 1..16
//  REFRESH_DIV   1000  clk cycles per digit slot, >=2
//  COMMON_ANODE  0     0: seg/dig active-high (CC); 1: all seg/dig outputs active-low
// PORTS
//  clk         in   1             system clock, rising edge
//  rst         in   1             async reset, active-high
//  load        in   1             capture data_in/blank_in into the pending buffer
//  data_in     in   4*NUM_DIGITS  nibble i = digit i, digit 0 = rightmost
//  blank_in    in   NUM_DIGITS    1 = digit i blank (segments off)
//  seg_out     out  7             {a,b,c,d,e,f,g}, a = MSB
//  dig_en      out  NUM_DIGITS    one-hot digit enable
//  frame_done  out  1             1-cycle pulse at the end of each full scan
// BEHAVIOUR
//  Reset (async, rst=1):
//  - Prescaler, digit index, pending buffer and display buffer cleared to 0.
//  - seg_out and dig_en inactive: 0 if COMMON_ANODE=0, all-ones if 1.
//  - frame_done = 0.
//  - Asserting rst mid-frame aborts the scan immediately; pending load data is lost.
//  Counters:
//  - psc counts 0..REFRESH_DIV-1, then wraps to 0.
//  - On psc==REFRESH_DIV-1: idx advances 0..NUM_DIGITS-1, wrapping to 0.
//  - NUM_DIGITS=1: idx is a constant 0 (no zero-width vector).
//  Outputs (registered, one cycle after counter state):
//  - psc==0 (dead cycle): dig_en and seg_out inactive.
//  - psc!=0: dig_en = onehot(idx); seg_out = decode(display nibble idx), or all segments off if display blank bit idx=1.
//  - Polarity: COMMON_ANODE=1 inverts both seg_out and dig_en.
//  Decode, active-high form:
//  - 0=1111110  1=0110000  2=1101101  3=1111001  4=0110011  5=1011011
//  - 6=1011111  7=1110000  8=1111111  9=1111011  A=1110111  b=0011111
//  - C=1001110  d=0111101  E=1001111  F=1000111
//  frame_done:
//  - Pulses (registered) in the cycle after idx==NUM_DIGITS-1 && psc==REFRESH_DIV-1.
//  Buffering:
//  - load=1: pending <= {data_in, blank_in}; sets a pending-valid flag.
//  - At the frame boundary (the same condition that drives frame_done), if pending-valid: display <= pending, flag cleared.
//  - Multiple loads in one frame: the last one wins.
//  - load in the boundary cycle itself: display <= data_in/blank_in directly; flag stays clear.
//  - Before the first swap after reset, the display shows digit 0 on every position (buffer = 0).
// CONFIGURATION
//  SEVSEG_DP_EN defined:
//  - Extra ports: dp_in (in, NUM_DIGITS) and dp_out (out, 1).
//  - dp_in is captured and double-buffered exactly like blank_in.
//  - dp_out is driven like a segment: inactive in the dead cycle and on blanked digits.
//  - dp_out follows COMMON_ANODE polarity; reset value is inactive.
//  SEVSEG_DP_EN undefined: ports dp_in and dp_out do not exist; no DP logic.
// TESTING  (NUM_DIGITS=4, REFRESH_DIV=4, COMMON_ANODE=0 unless stated)
//  1 Reset mid-scan, rst=1 -> seg_out=0, dig_en=0, frame_done=0 in the same cycle, no clk edge needed.
//  2 After release, no load -> dig_en 0001,0010,0100,1000 each for 3 cycles after 1 dead cycle;
//    seg_out=1111110; frame_done pulses every 16 cycles.
//  3 load data_in=16'hA5F0, blank_in=0 -> unchanged until the next frame_done;
//    then digits 0..3 show 1111110,1000111,1011011,1110111.
//  4 Two loads in one frame (16'h1234, then 16'hBEEF) -> only BEEF is displayed;
//    load coincident with the boundary -> that value is shown in the very next frame.
//  5 blank_in=4'b0100 -> digit 2 slot: dig_en=0100, seg_out=0000000; other digits decode normally.
//  6 COMMON_ANODE=1, digit 8 -> seg_out=0000000 and dig_en=1110 in digit 0 slot; dead cycle gives all-ones.
//    With SEVSEG_DP_EN and dp_in=0001 -> dp_out=0 only in the digit 0 slot.

Source files
------------

// File: rtl/sevenseg_mux_driver.sv
// Time-multiplexed N-digit hex 7-segment driver with frame-synchronous double buffering.
// Defining SEVSEG_DP_EN adds the decimal point ports dp_in/dp_out.
module sevenseg_mux_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 1000,
   parameter int COMMON_ANODE = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   output logic [6:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   dig_en,
   output logic                    frame_done
`ifdef SEVSEG_DP_EN
   ,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   output logic                    dp_out
`endif
);
   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] PSC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic CA = (COMMON_ANODE != 0);
   localparam logic [6:0] SEG_OFF = {7{CA}};
   localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{CA}};
`ifdef SEVSEG_DP_EN
   localparam int AW = 2*NUM_DIGITS;
`else
   localparam int AW = NUM_DIGITS;
`endif

   logic [PW-1:0]           r_psc;
   logic [IW-1:0]           w_idx;
   logic                    w_psc_wrap;
   logic                    w_boundary;
   logic [4*NUM_DIGITS-1:0] r_pend_dat, r_disp_dat;
   logic [AW-1:0]           r_pend_attr, r_disp_attr, w_attr_in;
   logic                    r_pend_vld;
   logic [3:0]              w_nib;
   logic                    w_blank;
   logic                    w_dp;
   logic [NUM_DIGITS-1:0]   w_onehot;
   logic [6:0]              w_dec;
   logic [6:0]              r_seg;
   logic [NUM_DIGITS-1:0]   r_dig;
   logic                    r_frame_done;

`ifdef SEVSEG_DP_EN
   assign w_attr_in = {dp_in, blank_in};
`else
   assign w_attr_in = blank_in;
`endif

   assign w_psc_wrap = (r_psc == PSC_LAST);
   assign w_boundary = w_psc_wrap && (w_idx == IDX_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_psc <= '0;
      else     r_psc <= w_psc_wrap ? '0 : r_psc + PW'(1);
   end

   generate
      if (NUM_DIGITS == 1) begin : g_idx_one
         assign w_idx = '0;
      end else begin : g_idx_cnt
         logic [IW-1:0] r_idx;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)             r_idx <= '0;
            else if (w_psc_wrap) r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
         end
         assign w_idx = r_idx;
      end
   endgenerate

   // A load in the boundary cycle bypasses the pending stage and is shown next frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend_dat  <= '0;
         r_pend_attr <= '0;
         r_pend_vld  <= 1'b0;
         r_disp_dat  <= '0;
         r_disp_attr <= '0;
      end else begin
         if (load) begin
            r_pend_dat  <= data_in;
            r_pend_attr <= w_attr_in;
         end
         if (w_boundary) begin
            r_pend_vld <= 1'b0;
            if (load) begin
               r_disp_dat  <= data_in;
               r_disp_attr <= w_attr_in;
            end else if (r_pend_vld) begin
               r_disp_dat  <= r_pend_dat;
               r_disp_attr <= r_pend_attr;
            end
         end else if (load) begin
            r_pend_vld <= 1'b1;
         end
      end
   end

   always_comb begin
      w_nib    = 4'h0;
      w_blank  = 1'b0;
      w_dp     = 1'b0;
      w_onehot = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (w_idx == IW'(i)) begin
            w_nib       = r_disp_dat[4*i +: 4];
            w_blank     = r_disp_attr[i];
            w_onehot[i] = 1'b1;
`ifdef SEVSEG_DP_EN
            w_dp        = r_disp_attr[NUM_DIGITS+i];
`endif
         end
      end
   end

   always_comb begin
      w_dec = 7'b0000000;
      case (w_nib)
         4'h0: w_dec = 7'b1111110;
         4'h1: w_dec = 7'b0110000;
         4'h2: w_dec = 7'b1101101;
         4'h3: w_dec = 7'b1111001;
         4'h4: w_dec = 7'b0110011;
         4'h5: w_dec = 7'b1011011;
         4'h6: w_dec = 7'b1011111;
         4'h7: w_dec = 7'b1110000;
         4'h8: w_dec = 7'b1111111;
         4'h9: w_dec = 7'b1111011;
         4'hA: w_dec = 7'b1110111;
         4'hB: w_dec = 7'b0011111;
         4'hC: w_dec = 7'b1001110;
         4'hD: w_dec = 7'b0111101;
         4'hE: w_dec = 7'b1001111;
         4'hF: w_dec = 7'b1000111;
         default: w_dec = 7'b0000000;
      endcase
   end

   // psc==0 is the anti-ghosting dead slot: everything dark while the digit changes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_seg        <= SEG_OFF;
         r_dig        <= DIG_OFF;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_boundary;
         if (r_psc == '0) begin
            r_seg <= SEG_OFF;
            r_dig <= DIG_OFF;
         end else begin
            r_seg <= (w_blank ? 7'b0000000 : w_dec) ^ SEG_OFF;
            r_dig <= w_onehot ^ DIG_OFF;
         end
      end
   end

`ifdef SEVSEG_DP_EN
   logic r_dp;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)               r_dp <= CA;
      else if (r_psc == '0)  r_dp <= CA;
      else                   r_dp <= (w_dp && !w_blank) ^ CA;
   end
   assign dp_out = r_dp;
`else
   logic w_dp_unused;
   assign w_dp_unused = w_dp;
`endif

   assign seg_out    = r_seg;
   assign dig_en     = r_dig;
   assign frame_done = r_frame_done;

endmodule
